// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: FSM encoding, grant encoding and latency bounds.
package mem_arb_pkg;

   localparam int unsigned LATENCY_MIN = 1;
   localparam int unsigned LATENCY_MAX = 15;
   localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one fixed-latency memory port.
// Define MEM_ARB_RR_EN for round-robin on contention; default is data-over-fetch priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Out-of-range LATENCY is clamped rather than left to wrap the counter.
   localparam int unsigned LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                                   (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_C - 1);

   state_t              r_state, w_state_d;
   logic [CNT_W-1:0]    r_cnt, w_cnt_d;
   gnt_t                r_gnt;
   gnt_t                w_win;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_d_rdata;
   logic                w_load;
   logic                w_capture;

`ifdef MEM_ARB_RR_EN
   gnt_t r_last;

   always_comb begin
      w_win = GNT_IF;
      if (if_req && d_req) begin
         w_win = (r_last == GNT_IF) ? GNT_D : GNT_IF;
      end else if (d_req) begin
         w_win = GNT_D;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= GNT_IF;
      end else if (w_load) begin
         r_last <= w_win;
      end
   end
`else
   always_comb begin
      w_win = d_req ? GNT_D : GNT_IF;
   end
`endif

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_load    = 1'b0;
      w_capture = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (if_req || d_req) begin
               w_load    = 1'b1;
               w_cnt_d   = CNT_LOAD;
               w_state_d = StBusy;
            end
         end
         StBusy: begin
            if (r_cnt == '0) begin
               w_capture = 1'b1;
               w_state_d = StDone;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Fetches carry no write data, so r_wdata keeps whatever the last write left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gnt   <= GNT_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_load) begin
         r_gnt <= w_win;
         if (w_win == GNT_D) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
         end else begin
            r_we   <= 1'b0;
            r_addr <= if_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else if (w_capture) begin
         if (r_gnt == GNT_IF) begin
            r_if_rdata <= mem_rdata;
         end else begin
            r_d_rdata <= mem_rdata;
         end
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_read  = (r_state == StBusy) && !r_we;
   assign mem_write = (r_state == StBusy) && r_we;
   assign if_ack    = (r_state == StDone) && (r_gnt == GNT_IF);
   assign d_ack     = (r_state == StDone) && (r_gnt == GNT_D);
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

endmodule
